// File: rtl/fifo_unpack.sv
// Drains a first-word-fall-through FIFO and emits each word as Ratio narrow
// chunks on a valid/ready stream, one chunk per cycle with no bubble between words.
module fifo_unpack #(
  parameter int InWidth    = 16,
  parameter int OutWidth   = 4,
  parameter int CountWidth = 2,
  parameter bit MsbFirst   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fifo_empty,
  input  logic [InWidth-1:0]  fifo_data,
  output logic                fifo_read,
  output logic                out_valid,
  output logic [OutWidth-1:0] out_data,
  output logic                out_last,
  input  logic                out_ready,
  output logic                busy
);

  localparam int Ratio = InWidth / OutWidth;
  localparam logic [CountWidth-1:0] LastIdx = CountWidth'(Ratio - 1);

  if ((InWidth % OutWidth) != 0 || Ratio < 2 || (2 ** CountWidth) < Ratio) begin : g_bad_params
    $error("fifo_unpack: InWidth/OutWidth/CountWidth combination is illegal");
  end

  logic [InWidth-1:0]    word_reg;
  logic [CountWidth-1:0] chunk_idx;
  logic                  holding;

  logic xfer, at_last, done, load;

  assign xfer    = holding & out_ready;
  assign at_last = (chunk_idx == LastIdx);
  assign done    = xfer & at_last;
  // Refill in the same cycle the last chunk leaves, so the stream never bubbles.
  assign load    = ~fifo_empty & (~holding | done);

  assign fifo_read = load & ~reset;
  assign out_valid = holding;
  assign out_last  = holding & at_last;
  assign busy      = holding | ~fifo_empty;

  // Chunk k of the held word, already placed in transmit order.
  logic [Ratio-1:0][OutWidth-1:0] chunk;

  for (genvar k = 0; k < Ratio; k++) begin : g_chunk
    if (MsbFirst) begin : g_msb
      assign chunk[k] = word_reg[InWidth-1-k*OutWidth -: OutWidth];
    end else begin : g_lsb
      assign chunk[k] = word_reg[k*OutWidth +: OutWidth];
    end
  end

  assign out_data = chunk[chunk_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      holding   <= 1'b0;
      chunk_idx <= '0;
      word_reg  <= '0;
    end else if (load) begin
      word_reg  <= fifo_data;
      chunk_idx <= '0;
      holding   <= 1'b1;
    end else if (done) begin
      holding   <= 1'b0;
      chunk_idx <= '0;
    end else if (xfer) begin
      chunk_idx <= chunk_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_unpack.sv
// Bench for fifo_unpack: MSB-first and LSB-first instances share one FIFO model;
// a monitor scores accepted chunks against queues filled when words are pushed.
module tb_fifo_unpack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        fifo_empty;
  logic [15:0] fifo_data;
  logic        out_ready;

  logic       fifo_read_m, out_valid_m, out_last_m, busy_m;
  logic [3:0] out_data_m;
  logic       fifo_read_l, out_valid_l, out_last_l, busy_l;
  logic [3:0] out_data_l;

  fifo_unpack #(.InWidth(16), .OutWidth(4), .CountWidth(2), .MsbFirst(1'b1)) dut_m (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_read(fifo_read_m), .out_valid(out_valid_m), .out_data(out_data_m),
    .out_last(out_last_m), .out_ready(out_ready), .busy(busy_m));

  fifo_unpack #(.InWidth(16), .OutWidth(4), .CountWidth(2), .MsbFirst(1'b0)) dut_l (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_read(fifo_read_l), .out_valid(out_valid_l), .out_data(out_data_l),
    .out_last(out_last_l), .out_ready(out_ready), .busy(busy_l));

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] data;
    logic       last;
  } exp_t;

  logic [15:0] fq[$];
  exp_t        exp_m[$];
  exp_t        exp_l[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void refresh();
    fifo_empty = (fq.size() == 0);
    if (fq.size() == 0) fifo_data = 16'h0;
    else fifo_data = fq[0];
  endfunction

  function automatic void push_word(input logic [15:0] w);
    fq.push_back(w);
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e.last = (k == 3);
      e.data = w[15-4*k -: 4];
      exp_m.push_back(e);
      e.data = w[4*k +: 4];
      exp_l.push_back(e);
    end
    refresh();
  endfunction

  // FWFT FIFO model: pop is applied just after the edge that sampled fifo_read.
  logic pop_now;
  always @(posedge clk) begin
    pop_now = fifo_read_m;
    #1;
    if (pop_now && fq.size() != 0) void'(fq.pop_front());
    refresh();
  end

  // Monitor: samples shortly before each rising edge, when handshakes are final.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      chk("read_while_empty", {31'd0, fifo_read_m & fifo_empty}, 32'd0);
      if (out_valid_m && out_ready) begin
        if (exp_m.size() == 0) begin
          checks++; errors++;
          $display("FAIL msb_unexpected: got chunk %0h expected none", out_data_m);
        end else begin
          e = exp_m.pop_front();
          chk("msb_data", {28'd0, out_data_m}, {28'd0, e.data});
          chk("msb_last", {31'd0, out_last_m}, {31'd0, e.last});
        end
      end
      if (out_valid_l && out_ready) begin
        if (exp_l.size() == 0) begin
          checks++; errors++;
          $display("FAIL lsb_unexpected: got chunk %0h expected none", out_data_l);
        end else begin
          e = exp_l.pop_front();
          chk("lsb_data", {28'd0, out_data_l}, {28'd0, e.data});
          chk("lsb_last", {31'd0, out_last_l}, {31'd0, e.last});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  logic [3:0] t_a5c3_m [4];
  logic [3:0] t_a5c3_l [4];
  logic [3:0] t_b2b    [8];
  logic [3:0] t_0f0f   [4];

  initial begin
    t_a5c3_m = '{4'hA, 4'h5, 4'hC, 4'h3};
    t_a5c3_l = '{4'h3, 4'hC, 4'h5, 4'hA};
    t_b2b    = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'hB, 4'hC, 4'hD};
    t_0f0f   = '{4'h0, 4'hF, 4'h0, 4'hF};

    reset = 1'b1;
    out_ready = 1'b0;
    refresh();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid_m}, 0);
    chk("rst_last", {31'd0, out_last_m}, 0);
    chk("rst_data", {28'd0, out_data_m}, 0);
    chk("rst_read", {31'd0, fifo_read_m}, 0);
    chk("rst_busy", {31'd0, busy_m}, 0);
    chk("rst_valid_l", {31'd0, out_valid_l}, 0);

    // Word waiting during reset: busy tracks the FIFO, but no pop yet.
    push_word(16'hA5C3);
    out_ready = 1'b1;
    #1;
    chk("rst_busy_nonempty", {31'd0, busy_m}, 1);
    chk("rst_read_blocked", {31'd0, fifo_read_m}, 0);

    // MSB-first and LSB-first order, single word.
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("order_pop", {31'd0, fifo_read_m}, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("order_valid", {31'd0, out_valid_m}, 1);
      chk("order_msb", {28'd0, out_data_m}, {28'd0, t_a5c3_m[i]});
      chk("order_lsb", {28'd0, out_data_l}, {28'd0, t_a5c3_l[i]});
      chk("order_last", {31'd0, out_last_m}, (i == 3) ? 32'd1 : 32'd0);
      chk("order_no_read", {31'd0, fifo_read_m}, 0);
    end
    @(negedge clk); #1;
    chk("order_idle_valid", {31'd0, out_valid_m}, 0);
    chk("order_idle_busy", {31'd0, busy_m}, 0);

    // Back-to-back words, refill coincides with the last chunk.
    push_word(16'h1234);
    push_word(16'hABCD);
    #1;
    chk("b2b_pop0", {31'd0, fifo_read_m}, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      chk("b2b_valid", {31'd0, out_valid_m}, 1);
      chk("b2b_data", {28'd0, out_data_m}, {28'd0, t_b2b[i]});
      chk("b2b_read", {31'd0, fifo_read_m}, (i == 3) ? 32'd1 : 32'd0);
    end
    @(negedge clk); #1;
    chk("b2b_idle_valid", {31'd0, out_valid_m}, 0);
    chk("b2b_idle_busy", {31'd0, busy_m}, 0);

    // Backpressure on chunk C with another word queued behind.
    push_word(16'hA5C3);
    push_word(16'h5A5A);
    #1;
    chk("bp_pop", {31'd0, fifo_read_m}, 1);
    @(negedge clk); #1;
    chk("bp_chunk_a", {28'd0, out_data_m}, 32'hA);
    @(negedge clk); #1;
    chk("bp_chunk_5", {28'd0, out_data_m}, 32'h5);
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("bp_hold_data", {28'd0, out_data_m}, 32'hC);
      chk("bp_hold_valid", {31'd0, out_valid_m}, 1);
      chk("bp_hold_last", {31'd0, out_last_m}, 0);
      chk("bp_hold_read", {31'd0, fifo_read_m}, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp_resume_c", {28'd0, out_data_m}, 32'hC);
    chk("bp_resume_read", {31'd0, fifo_read_m}, 0);
    @(negedge clk); #1;
    chk("bp_resume_3", {28'd0, out_data_m}, 32'h3);
    chk("bp_resume_last", {31'd0, out_last_m}, 1);
    chk("bp_refill_read", {31'd0, fifo_read_m}, 1);
    begin
      int n = 0;
      while (out_valid_m && n < 10) begin
        @(negedge clk); #1;
        n++;
      end
      chk("bp_drain_timeout", {31'd0, out_valid_m}, 0);
    end
    chk("bp_scoreboard_empty", exp_m.size() + exp_l.size(), 0);

    // Empty FIFO: nothing moves.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      chk("empty_read", {31'd0, fifo_read_m}, 0);
      chk("empty_valid", {31'd0, out_valid_m}, 0);
      chk("empty_busy", {31'd0, busy_m}, 0);
    end

    // Reset mid-word: C and 3 are discarded, next word follows cleanly.
    push_word(16'hA5C3);
    push_word(16'h0F0F);
    #1;
    chk("rmw_pop", {31'd0, fifo_read_m}, 1);
    @(negedge clk); #1;
    chk("rmw_chunk_a", {28'd0, out_data_m}, 32'hA);
    @(negedge clk); #1;
    chk("rmw_chunk_5", {28'd0, out_data_m}, 32'h5);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_m.delete(0);
      exp_l.delete(0);
    end
    #1;
    chk("rmw_rst_read", {31'd0, fifo_read_m}, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rmw_after_valid", {31'd0, out_valid_m}, 0);
    chk("rmw_after_pop", {31'd0, fifo_read_m}, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("rmw_valid", {31'd0, out_valid_m}, 1);
      chk("rmw_data", {28'd0, out_data_m}, {28'd0, t_0f0f[i]});
    end
    @(negedge clk); #1;
    chk("rmw_idle_valid", {31'd0, out_valid_m}, 0);
    chk("rmw_idle_busy", {31'd0, busy_m}, 0);
    chk("final_scoreboard_empty", exp_m.size() + exp_l.size(), 0);
    chk("final_fifo_empty", fq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
